// File: rtl/md_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// md_defs : shared definitions for the multiply/divide sequencing controller.
//   - MD_* operation codes presented on req_op
//   - RD_* read selectors presented on rd_sel
//   - FSM state encoding (ST_IDLE / ST_RUN)
//   - helper functions classifying an op code
// No ports (package).
// -----------------------------------------------------------------------------
package md_defs;

   localparam logic [3:0] MD_NOP   = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MADD  = 4'd5;
   localparam logic [3:0] MD_MADDU = 4'd6;
   localparam logic [3:0] MD_MSUB  = 4'd7;
   localparam logic [3:0] MD_MSUBU = 4'd8;
   localparam logic [3:0] MD_MTHI  = 4'd9;
   localparam logic [3:0] MD_MTLO  = 4'd10;

   localparam logic [1:0] RD_NONE = 2'd0;
   localparam logic [1:0] RD_HI   = 2'd1;
   localparam logic [1:0] RD_LO   = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   // Multiply-class ops, including the accumulating forms.
   function automatic logic is_mul(input logic [3:0] op);
      return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return op inside {MD_DIV, MD_DIVU};
   endfunction

   // Ops whose operands are sign-extended; the U variants zero-extend.
   function automatic logic is_signed_op(input logic [3:0] op);
      return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
   endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// -----------------------------------------------------------------------------
// md_ctrl_if : EX-stage <-> multiply/divide controller signal bundle.
//   req_valid/req_op/req_rs/req_rt : request from EX stage
//   abort                          : exception flush
//   rd_sel / rd_data               : MFHI/MFLO read path
//   stall / busy                   : pipeline freeze and op-in-flight flags
//   hi / lo                        : architectural HI/LO registers
// Modports: master (EX stage side), slave (controller side).
// -----------------------------------------------------------------------------
interface md_ctrl_if;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_rs;
   logic [31:0] req_rt;
   logic        abort;
   logic [1:0]  rd_sel;
   logic [31:0] rd_data;
   logic        stall;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req_valid, req_op, req_rs, req_rt, abort, rd_sel,
      input  rd_data, stall, busy, hi, lo
   );

   modport slave (
      input  req_valid, req_op, req_rs, req_rt, abort, rd_sel,
      output rd_data, stall, busy, hi, lo
   );
endinterface

// File: rtl/md_ctrl_compute.sv
// -----------------------------------------------------------------------------
// md_compute : purely combinational HI/LO result generator.
//   op_q, rs_q, rt_q : latched operation and operands
//   hi, lo           : current architectural HI/LO (accumulator for MADD/MSUB)
//   next_hi, next_lo : values to commit at completion (hi/lo for non-result ops)
//   div0             : divide op with a zero divisor (result suppressed)
// -----------------------------------------------------------------------------
module md_compute
   import md_defs::*;
(
   input  logic [3:0]  op_q,
   input  logic [31:0] rs_q,
   input  logic [31:0] rt_q,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] next_hi,
   output logic [31:0] next_lo,
   output logic        div0
);

   logic        sgn;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic [63:0] acc;
   logic [63:0] res;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quo;
   logic [31:0] rem;

   always_comb begin
      sgn   = is_signed_op(op_q);
      // Low 64 bits of the product of the extended operands equal the exact
      // signed or unsigned 32x32 product.
      ext_a = sgn ? {{32{rs_q[31]}}, rs_q} : {32'd0, rs_q};
      ext_b = sgn ? {{32{rt_q[31]}}, rt_q} : {32'd0, rt_q};
      prod  = ext_a * ext_b;
      acc   = {hi, lo};

      // Signed division via magnitudes: quotient truncates toward zero and
      // the remainder follows the dividend's sign. Doing it this way keeps
      // the most-negative / -1 case well defined.
      mag_a   = (sgn && rs_q[31]) ? (~rs_q + 32'd1) : rs_q;
      mag_b   = (sgn && rt_q[31]) ? (~rt_q + 32'd1) : rt_q;
      divisor = (rt_q == 32'd0) ? 32'd1 : mag_b;
      q_mag   = mag_a / divisor;
      r_mag   = mag_a % divisor;
      quo     = (sgn && (rs_q[31] ^ rt_q[31])) ? (~q_mag + 32'd1) : q_mag;
      rem     = (sgn && rs_q[31]) ? (~r_mag + 32'd1) : r_mag;

      div0 = is_div(op_q) && (rt_q == 32'd0);

      res = acc;
      case (op_q)
         MD_MULT, MD_MULTU: res = prod;
         MD_MADD, MD_MADDU: res = acc + prod;
         MD_MSUB, MD_MSUBU: res = acc - prod;
         MD_DIV,  MD_DIVU:  res = div0 ? acc : {rem, quo};
         default:           res = acc;
      endcase
      next_hi = res[63:32];
      next_lo = res[31:0];
   end

endmodule

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl : sequencing controller for the EX-stage multiply/divide resource.
//   Accepts one HI/LO operation at a time, latches its operands, holds busy
//   for MULT_LAT / DIV_LAT cycles, commits HI/LO at completion and stalls
//   later MD/MF instructions. abort cancels an in-flight op and blocks issue.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : md_ctrl_if.slave (request, abort, read path, stall/busy, hi/lo)
// Parameters:
//   MULT_LAT : busy cycles for multiply-class ops (1..15)
//   DIV_LAT  : busy cycles for divide ops (1..15)
// Build option:
//   MD_FWD_EN : when defined, the final RUN cycle does not stall; rd_data
//               forwards the pending commit and a new request issues on the
//               completion edge.
// -----------------------------------------------------------------------------
module md_ctrl
   import md_defs::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
)(
   input  logic    clk,
   input  logic    rst_n,
   md_ctrl_if.slave bus
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   md_state_t   state_reg;
   md_state_t   state_next;
   logic [3:0]  cnt_reg;
   logic [3:0]  op_q;
   logic [31:0] rs_q;
   logic [31:0] rt_q;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;

   logic [31:0] next_hi;
   logic [31:0] next_lo;
   logic        div0;

   logic        busy;
   logic        last_cycle;
   logic        finish;
   logic        fwd_open;
   logic        accept;
   logic        start_op;
   logic        stall;
   logic [31:0] view_hi;
   logic [31:0] view_lo;
   logic [31:0] rd_data;

   md_compute u_compute (
      .op_q    (op_q),
      .rs_q    (rs_q),
      .rt_q    (rt_q),
      .hi      (hi_reg),
      .lo      (lo_reg),
      .next_hi (next_hi),
      .next_lo (next_lo),
      .div0    (div0)
   );

   assign busy       = (state_reg == ST_RUN);
   assign last_cycle = busy && (cnt_reg == 4'd1);
   assign finish     = last_cycle && !bus.abort;

`ifdef MD_FWD_EN
   // Final RUN cycle behaves like IDLE towards the pipeline.
   assign fwd_open = last_cycle;
`else
   assign fwd_open = 1'b0;
`endif

   // Accepting while fwd_open implies !abort, i.e. this is the commit edge,
   // so a new op never overlaps an uncommitted one.
   assign accept   = bus.req_valid && !bus.abort && (!busy || fwd_open);
   assign start_op = accept && (is_mul(bus.req_op) || is_div(bus.req_op));

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_op) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (bus.abort)
               state_next = ST_IDLE;
            else if (cnt_reg == 4'd1)
               state_next = start_op ? ST_RUN : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      stall   = busy && (bus.req_valid || (bus.rd_sel != RD_NONE))
                && !bus.abort && !fwd_open;
      view_hi = (fwd_open && finish) ? next_hi : hi_reg;
      view_lo = (fwd_open && finish) ? next_lo : lo_reg;
      rd_data = 32'd0;
      if (!stall) begin
         case (bus.rd_sel)
            RD_HI:   rd_data = view_hi;
            RD_LO:   rd_data = view_lo;
            default: rd_data = 32'd0;
         endcase
      end
   end

   // Counter, operand latches and HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= 4'd0;
         op_q    <= MD_NOP;
         rs_q    <= 32'd0;
         rt_q    <= 32'd0;
         hi_reg  <= 32'd0;
         lo_reg  <= 32'd0;
      end else begin
         if (start_op) begin
            op_q    <= bus.req_op;
            rs_q    <= bus.req_rs;
            rt_q    <= bus.req_rt;
            cnt_reg <= is_div(bus.req_op) ? DIV_CNT : MULT_CNT;
         end else if (busy) begin
            cnt_reg <= bus.abort ? 4'd0 : (cnt_reg - 4'd1);
         end

         if (finish && !div0) begin
            hi_reg <= next_hi;
            lo_reg <= next_lo;
         end
         // A move issued on the commit edge is younger than the committing op.
         if (accept && (bus.req_op == MD_MTHI)) hi_reg <= bus.req_rs;
         if (accept && (bus.req_op == MD_MTLO)) lo_reg <= bus.req_rs;
      end
   end

   assign bus.stall   = stall;
   assign bus.busy    = busy;
   assign bus.rd_data = rd_data;
   assign bus.hi      = hi_reg;
   assign bus.lo      = lo_reg;

endmodule
